// File: rtl/life_stream_engine.sv
// life_stream_engine: streaming Game-of-Life generation engine for a W x H grid.
// Cells arrive one per accepted beat in row-major order; the next generation
// leaves in the same order, one registered output per window push.
// Build option: define LIFE_HIGHLIFE_EN to use the HighLife rule (B36/S23)
// instead of the standard Conway rule (B3/S23).
//
// state | meaning
// FILL  | accepting the first W+1 cells of a frame, no centre complete yet
// RUN   | accepting cells, one next-generation cell emitted per accept
// FLUSH | input closed, zero pushes drain the last W+1 centres of the frame
module life_stream_engine #(
  parameter int W     = 8,
  parameter int H     = 8,
  parameter int GEN_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_cell,
  output logic                 out_valid,
  output logic                 out_cell,
  output logic [$clog2(W)-1:0] out_x,
  output logic [$clog2(H)-1:0] out_y,
  output logic                 out_last,
  output logic                 frame_done,
  output logic [GEN_W-1:0]     gen_cnt
);

  localparam int N   = W * H;
  localparam int WL  = 2 * W + 3;
  localparam int PCW = $clog2(N + W + 1);
  localparam int XW  = $clog2(W);
  localparam int YW  = $clog2(H);

  localparam logic [PCW-1:0] P_FILL_END  = PCW'(W);
  localparam logic [PCW-1:0] P_RUN_END   = PCW'(N - 1);
  localparam logic [PCW-1:0] P_FLUSH_END = PCW'(N + W);
  localparam logic [XW-1:0]  X_MAX       = XW'(W - 1);
  localparam logic [YW-1:0]  Y_MAX       = YW'(H - 1);

  typedef enum logic [1:0] {
    S_FILL  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2
  } state_t;

  state_t state_q, state_d;

  // The oldest window slot (lu tap) is only ever read in the cycle it is
  // shifted out, so only WL-1 bits need storage; the incoming cell completes
  // the 2W+3 view combinationally.
  logic [WL-2:0]    win_q, win_d;
  logic [WL-1:0]    win_sh;
  logic [PCW-1:0]   push_cnt_q, push_cnt_d;
  logic [XW-1:0]    cx_q, cx_d;
  logic [YW-1:0]    cy_q, cy_d;

  logic             out_valid_q, out_valid_d;
  logic             out_cell_q, out_cell_d;
  logic [XW-1:0]    out_x_q, out_x_d;
  logic [YW-1:0]    out_y_q, out_y_d;
  logic             out_last_q, out_last_d;
  logic             frame_done_q, frame_done_d;
  logic [GEN_W-1:0] gen_cnt_q, gen_cnt_d;

  logic accept;
  logic push;
  logic emit;
  logic push_bit;
  logic last_push;

  logic m_l, m_r, m_u, m_d;
  logic t_l, t_r, t_u, t_d, t_lu, t_ru, t_ld, t_rd;
  logic centre;
  logic [3:0] n_live;
  logic next_cell;

  assign in_ready = ~rst & (state_q != S_FLUSH);
  assign accept   = in_valid & in_ready;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FILL;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and push/emit control for the current cycle.
  always_comb begin
    state_d   = state_q;
    push      = 1'b0;
    emit      = 1'b0;
    push_bit  = 1'b0;
    last_push = 1'b0;
    case (state_q)
      S_FILL: begin
        if (accept) begin
          push     = 1'b1;
          push_bit = in_cell;
          if (push_cnt_q == P_FILL_END) state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (accept) begin
          push     = 1'b1;
          emit     = 1'b1;
          push_bit = in_cell;
          if (push_cnt_q == P_RUN_END) state_d = S_FLUSH;
        end
      end
      S_FLUSH: begin
        push = 1'b1;
        emit = 1'b1;
        if (push_cnt_q == P_FLUSH_END) begin
          last_push = 1'b1;
          state_d   = S_FILL;
        end
      end
      default: state_d = S_FILL;
    endcase
  end

  // Window taps around the centre that this push lands at slot W+1, with
  // grid-edge masking so nothing outside the grid (or from the previous
  // frame) contributes.
  always_comb begin
    win_sh = {win_q, push_bit};
    m_l    = (cx_q != '0);
    m_r    = (cx_q != X_MAX);
    m_u    = (cy_q != '0);
    m_d    = (cy_q != Y_MAX);
    centre = win_sh[W+1];
    t_r    = win_sh[W]       & m_r;
    t_l    = win_sh[W+2]     & m_l;
    t_d    = win_sh[1]       & m_d;
    t_u    = win_sh[2*W+1]   & m_u;
    t_rd   = win_sh[0]       & m_r & m_d;
    t_ld   = win_sh[2]       & m_l & m_d;
    t_ru   = win_sh[2*W]     & m_r & m_u;
    t_lu   = win_sh[2*W+2]   & m_l & m_u;
    n_live = {3'b000, t_r}  + {3'b000, t_l}  + {3'b000, t_d}  + {3'b000, t_u} +
             {3'b000, t_rd} + {3'b000, t_ld} + {3'b000, t_ru} + {3'b000, t_lu};
`ifdef LIFE_HIGHLIFE_EN
    next_cell = (n_live == 4'd3) | (~centre & (n_live == 4'd6)) | (centre & (n_live == 4'd2));
`else
    next_cell = (n_live == 4'd3) | (centre & (n_live == 4'd2));
`endif
  end

  // Datapath next-state: window shift, push counter, centre coordinates,
  // registered outputs and generation bookkeeping.
  always_comb begin
    win_d        = win_q;
    push_cnt_d   = push_cnt_q;
    cx_d         = cx_q;
    cy_d         = cy_q;
    out_valid_d  = emit;
    out_cell_d   = 1'b0;
    out_x_d      = '0;
    out_y_d      = '0;
    out_last_d   = 1'b0;
    frame_done_d = out_valid_q & out_last_q;
    gen_cnt_d    = gen_cnt_q;

    if (push) begin
      win_d      = win_sh[WL-2:0];
      push_cnt_d = last_push ? '0 : push_cnt_q + PCW'(1);
    end

    if (emit) begin
      out_cell_d = next_cell;
      out_x_d    = cx_q;
      out_y_d    = cy_q;
      out_last_d = last_push;
      if (cx_q == X_MAX) begin
        cx_d = '0;
        cy_d = (cy_q == Y_MAX) ? '0 : cy_q + YW'(1);
      end else begin
        cx_d = cx_q + XW'(1);
      end
    end

    if (frame_done_d) gen_cnt_d = gen_cnt_q + GEN_W'(1);
  end

  // Datapath and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      win_q        <= '0;
      push_cnt_q   <= '0;
      cx_q         <= '0;
      cy_q         <= '0;
      out_valid_q  <= 1'b0;
      out_cell_q   <= 1'b0;
      out_x_q      <= '0;
      out_y_q      <= '0;
      out_last_q   <= 1'b0;
      frame_done_q <= 1'b0;
      gen_cnt_q    <= '0;
    end else begin
      win_q        <= win_d;
      push_cnt_q   <= push_cnt_d;
      cx_q         <= cx_d;
      cy_q         <= cy_d;
      out_valid_q  <= out_valid_d;
      out_cell_q   <= out_cell_d;
      out_x_q      <= out_x_d;
      out_y_q      <= out_y_d;
      out_last_q   <= out_last_d;
      frame_done_q <= frame_done_d;
      gen_cnt_q    <= gen_cnt_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_cell   = out_cell_q;
  assign out_x      = out_x_q;
  assign out_y      = out_y_q;
  assign out_last   = out_last_q;
  assign frame_done = frame_done_q;
  assign gen_cnt    = gen_cnt_q;

endmodule

// File: tb/tb_life_stream_engine.sv
// Directed bench for life_stream_engine on the default 8x8 grid.
// Grids are 64-bit vectors, bit index y*8+x.
module tb_life_stream_engine;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_cell = 1'b0;
  logic        out_valid;
  logic        out_cell;
  logic [2:0]  out_x;
  logic [2:0]  out_y;
  logic        out_last;
  logic        frame_done;
  logic [15:0] gen_cnt;

  int checks = 0;
  int errors = 0;

  logic [63:0] out_grid;
  int ov_cnt, fd_cnt, order_err, stall_viol, mon_idx, cyc;
  int last_cyc, fd_cyc, last_x, last_y, lst_cnt;

  always #5 clk = ~clk;

  life_stream_engine #(.W(8), .H(8), .GEN_W(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_cell    (in_cell),
    .out_valid  (out_valid),
    .out_cell   (out_cell),
    .out_x      (out_x),
    .out_y      (out_y),
    .out_last   (out_last),
    .frame_done (frame_done),
    .gen_cnt    (gen_cnt)
  );

  // Recorder: captures outputs shortly after each edge into the grid and counters.
  always @(posedge clk) begin
    logic stall;
    stall = in_ready && !in_valid;
    cyc = cyc + 1;
    #2;
    if (out_valid) begin
      ov_cnt = ov_cnt + 1;
      if ({out_y, out_x} != mon_idx[5:0]) order_err = order_err + 1;
      out_grid[{out_y, out_x}] = out_cell;
      mon_idx = (mon_idx + 1) % 64;
      if (out_last) begin
        last_cyc = cyc;
        last_x   = int'(out_x);
        last_y   = int'(out_y);
        lst_cnt  = lst_cnt + 1;
      end
    end
    if (stall && out_valid) stall_viol = stall_viol + 1;
    if (frame_done) begin
      fd_cnt = fd_cnt + 1;
      fd_cyc = cyc;
    end
  end

  task automatic clear_mon();
    ov_cnt = 0; fd_cnt = 0; order_err = 0; stall_viol = 0; mon_idx = 0;
    last_cyc = -10; fd_cyc = -20; last_x = -1; last_y = -1; lst_cnt = 0;
    out_grid = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0; in_cell = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    clear_mon();
  endtask

  task automatic feed(input logic [63:0] g, input bit gaps);
    int i;
    int budget;
    i = 0; budget = 0;
    while (i < 64 && budget < 1000) begin
      @(negedge clk);
      budget++;
      if (gaps && $urandom_range(0, 1) == 0) begin
        in_valid = 1'b0;
      end else begin
        in_valid = 1'b1;
        in_cell  = g[i];
        if (in_ready) i++;
      end
    end
    @(negedge clk);
    in_valid = 1'b0; in_cell = 1'b0;
    checks++;
    if (i != 64) begin
      errors++;
      $display("FAIL feed_accepts got %0d want 64", i);
    end
  endtask

  task automatic wait_fd(input int n);
    int b;
    b = 0;
    while (fd_cnt < n && b < 300) begin
      @(negedge clk);
      b++;
    end
    @(negedge clk);
    checks++;
    if (fd_cnt < n) begin
      errors++;
      $display("FAIL frame_done_timeout got %0d want %0d", fd_cnt, n);
    end
  endtask

  task automatic test_reset();
    cyc = 0;
    clear_mon();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
    checks++;
    if ({out_valid, out_cell, out_last, frame_done, out_x, out_y} !== 10'd0) begin
      errors++;
      $display("FAIL reset_outputs got %b want 0", {out_valid, out_cell, out_last, frame_done, out_x, out_y});
    end
    checks++;
    if (gen_cnt !== 16'd0) begin errors++; $display("FAIL reset_gen_cnt got %0d want 0", gen_cnt); end
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready got %b want 1", in_ready); end
  endtask

  task automatic test_all_ones();
    logic [63:0] exp;
    exp = '0; exp[0] = 1'b1; exp[7] = 1'b1; exp[56] = 1'b1; exp[63] = 1'b1;
    do_reset();
    feed({64{1'b1}}, 1'b0);
    wait_fd(1);
    checks++;
    if (out_grid !== exp) begin errors++; $display("FAIL all_ones_grid got %h want %h", out_grid, exp); end
    checks++;
    if (ov_cnt != 64 || order_err != 0) begin
      errors++;
      $display("FAIL all_ones_stream got count %0d order_err %0d want 64 0", ov_cnt, order_err);
    end
    checks++;
    if (last_x != 7 || last_y != 7 || lst_cnt != 1) begin
      errors++;
      $display("FAIL out_last_pos got (%0d,%0d) x%0d want (7,7) x1", last_x, last_y, lst_cnt);
    end
    checks++;
    if (fd_cyc != last_cyc + 1) begin
      errors++;
      $display("FAIL frame_done_timing got cyc %0d want %0d", fd_cyc, last_cyc + 1);
    end
    checks++;
    if (gen_cnt !== 16'd1) begin errors++; $display("FAIL all_ones_gen got %0d want 1", gen_cnt); end
  endtask

  task automatic test_blinker();
    logic [63:0] row, col, g;
    row = '0; row[26] = 1'b1; row[27] = 1'b1; row[28] = 1'b1;
    col = '0; col[19] = 1'b1; col[27] = 1'b1; col[35] = 1'b1;
    do_reset();
    feed(row, 1'b0);
    wait_fd(1);
    checks++;
    if (out_grid !== col) begin errors++; $display("FAIL blinker_pass1 got %h want %h", out_grid, col); end
    g = out_grid;
    clear_mon();
    feed(g, 1'b0);
    wait_fd(1);
    checks++;
    if (out_grid !== row) begin errors++; $display("FAIL blinker_pass2 got %h want %h", out_grid, row); end
    checks++;
    if (gen_cnt !== 16'd2) begin errors++; $display("FAIL blinker_gen got %0d want 2", gen_cnt); end
  endtask

  task automatic test_glider();
    logic [63:0] g, exp;
    g   = '0; g[1] = 1'b1; g[10] = 1'b1; g[16] = 1'b1; g[17] = 1'b1; g[18] = 1'b1;
    exp = '0; exp[10] = 1'b1; exp[19] = 1'b1; exp[25] = 1'b1; exp[26] = 1'b1; exp[27] = 1'b1;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      clear_mon();
      feed(g, 1'b0);
      wait_fd(1);
      g = out_grid;
    end
    checks++;
    if (g !== exp) begin errors++; $display("FAIL glider_shift got %h want %h", g, exp); end
    checks++;
    if (gen_cnt !== 16'd4) begin errors++; $display("FAIL glider_gen got %0d want 4", gen_cnt); end
  endtask

  task automatic test_stall_gaps();
    logic [63:0] blk;
    blk = '0; blk[0] = 1'b1; blk[1] = 1'b1; blk[8] = 1'b1; blk[9] = 1'b1;
    do_reset();
    feed(blk, 1'b1);
    wait_fd(1);
    checks++;
    if (out_grid !== blk) begin errors++; $display("FAIL gaps_block got %h want %h", out_grid, blk); end
    checks++;
    if (stall_viol != 0 || ov_cnt != 64) begin
      errors++;
      $display("FAIL gaps_stall got viol %0d count %0d want 0 64", stall_viol, ov_cnt);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [63:0] row, col;
    int i;
    int budget;
    row = '0; row[26] = 1'b1; row[27] = 1'b1; row[28] = 1'b1;
    col = '0; col[19] = 1'b1; col[27] = 1'b1; col[35] = 1'b1;
    do_reset();
    i = 0; budget = 0;
    while (i < 20 && budget < 200) begin
      @(negedge clk);
      budget++;
      in_valid = 1'b1;
      in_cell  = 1'b1;
      if (in_ready) i++;
    end
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0; in_cell = 1'b0;
    clear_mon();
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL midrst_in_ready got %b want 0", in_ready); end
    @(negedge clk);
    rst = 1'b0;
    repeat (100) @(negedge clk);
    checks++;
    if (ov_cnt != 0 || fd_cnt != 0 || gen_cnt !== 16'd0) begin
      errors++;
      $display("FAIL midrst_quiet got out %0d done %0d gen %0d want 0 0 0", ov_cnt, fd_cnt, gen_cnt);
    end
    clear_mon();
    feed(row, 1'b0);
    wait_fd(1);
    checks++;
    if (out_grid !== col) begin errors++; $display("FAIL midrst_frame got %h want %h", out_grid, col); end
    checks++;
    if (gen_cnt !== 16'd1) begin errors++; $display("FAIL midrst_gen got %0d want 1", gen_cnt); end
  endtask

  task automatic test_highlife();
    logic [63:0] g;
    logic exp_c;
`ifdef LIFE_HIGHLIFE_EN
    exp_c = 1'b1;
`else
    exp_c = 1'b0;
`endif
    g = '0;
    g[27] = 1'b1; g[28] = 1'b1; g[29] = 1'b1;
    g[43] = 1'b1; g[44] = 1'b1; g[45] = 1'b1;
    do_reset();
    feed(g, 1'b0);
    wait_fd(1);
    checks++;
    if (out_grid[36] !== exp_c) begin
      errors++;
      $display("FAIL six_neighbour_birth got %b want %b", out_grid[36], exp_c);
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] row, col;
    row = '0; row[26] = 1'b1; row[27] = 1'b1; row[28] = 1'b1;
    col = '0; col[19] = 1'b1; col[27] = 1'b1; col[35] = 1'b1;
    do_reset();
    feed({64{1'b1}}, 1'b0);
    feed(row, 1'b0);
    wait_fd(2);
    checks++;
    if (out_grid !== col) begin errors++; $display("FAIL b2b_grid got %h want %h", out_grid, col); end
    checks++;
    if (ov_cnt != 128 || order_err != 0 || fd_cnt != 2) begin
      errors++;
      $display("FAIL b2b_stream got out %0d order_err %0d done %0d want 128 0 2", ov_cnt, order_err, fd_cnt);
    end
    checks++;
    if (gen_cnt !== 16'd2) begin errors++; $display("FAIL b2b_gen got %0d want 2", gen_cnt); end
  endtask

  initial begin
    test_reset();
    test_all_ones();
    test_blinker();
    test_glider();
    test_stall_gaps();
    test_reset_mid_frame();
    test_highlife();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
